// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 sequencer. Holds the architectural CP0 state (STATUS, CAUSE,
// EPC, BADVADDR, COUNT, COMPARE), arbitrates between pipeline exceptions,
// hardware/timer interrupts and eret, and raises a flush + redirect request
// towards fetch that is held until fetch acknowledges it. It also serves the
// mfc0 (combinational read) and mtc0 (write at the clock edge) accesses issued
// from the MEM stage.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   pc_valid          MEM stage holds a real instruction (interrupts need it)
//   mem_pc            PC of the MEM-stage instruction
//   mem_in_ds         MEM instruction sits in a branch delay slot
//   exc_valid         MEM instruction raised an exception
//   exc_code          ExcCode of that exception
//   exc_badaddr       faulting address for AdEL/AdES
//   eret              MEM instruction is eret
//   int_in            level-sensitive hardware interrupt lines
//   cp0_we            mtc0 write strobe
//   cp0_addr/cp0_sel  CP0 register number / select (only select 0 exists)
//   cp0_wdata         mtc0 data
//   cp0_rdata         mfc0 data (combinational)
//   flush             kill IF..MEM
//   redirect_valid    redirect request to fetch
//   redirect_pc       redirect target
//   redirect_ack      fetch accepted the redirect
//   exl_out           STATUS.EXL
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VEC  = 32'h0000_3000,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_ds,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_badaddr,
  input  logic        eret,
  input  logic [5:0]  int_in,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [2:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        exl_out
);

  // CP0 register numbers (select 0)
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  // ExcCodes that carry a faulting address
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } state_t;

  state_t state;

  // Architectural state, kept as individual fields; unimplemented bits are
  // constant zero and only materialise in the read mux.
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;      // cause_ip[7:2] hardware, cause_ip[1:0] software
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;

  // ---------------------------------------------------------------------------
  // Event arbitration
  // ---------------------------------------------------------------------------
  logic int_pend;
  logic in_idle;
  logic take_exc;
  logic take_int;
  logic take_eret;
  logic take_any;
  logic wr_en;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_count;
  logic wr_compare;
  logic timer_hit;

  assign int_pend  = status_ie & ~status_exl & (|(cause_ip & status_im));
  assign in_idle   = (state == S_IDLE);

  // exception > interrupt (only on a real instruction) > eret
  assign take_exc  = in_idle & exc_valid;
  assign take_int  = in_idle & ~exc_valid & int_pend & pc_valid;
  assign take_eret = in_idle & ~exc_valid & ~(int_pend & pc_valid) & eret;
  assign take_any  = take_exc | take_int | take_eret;

  // mtc0 only lands in IDLE and only when no event is being taken this cycle,
  // so it never races the event updates of EXL/EPC below.
  assign wr_en      = in_idle & ~take_any & cp0_we & (cp0_sel == 3'd0);
  assign wr_status  = wr_en & (cp0_addr == ADDR_STATUS);
  assign wr_cause   = wr_en & (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = wr_en & (cp0_addr == ADDR_EPC);
  assign wr_count   = wr_en & (cp0_addr == ADDR_COUNT);
  assign wr_compare = wr_en & (cp0_addr == ADDR_COMPARE);

  assign timer_hit  = TIMER_EN && (count == compare);

  // ---------------------------------------------------------------------------
  // mfc0 read mux
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cp0_rdata = 32'h0;
    if (cp0_sel == 3'd0) begin
      unique case (cp0_addr)
        ADDR_BADVADDR: cp0_rdata = badvaddr;
        ADDR_COUNT:    cp0_rdata = count;
        ADDR_COMPARE:  cp0_rdata = compare;
        ADDR_STATUS:   cp0_rdata = {16'h0, status_im, 6'h0, status_exl, status_ie};
        ADDR_CAUSE:    cp0_rdata = {cause_bd, cause_ti, 14'h0, cause_ip, 1'b0,
                                    cause_exc, 2'b00};
        ADDR_EPC:      cp0_rdata = epc;
        default:       cp0_rdata = 32'h0;
      endcase
    end
  end

  assign exl_out = status_exl;

  // ---------------------------------------------------------------------------
  // State update and sequencer
  // ---------------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments, so every right-hand
  // side sees pre-edge values (e.g. eret redirects to the EPC held before the
  // edge, and IP[15] picks up the TI value from before the edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      status_ie      <= 1'b1;
      status_exl     <= 1'b0;
      status_im      <= 8'h0;
      cause_bd       <= 1'b0;
      cause_ti       <= 1'b0;
      cause_ip       <= 8'h0;
      cause_exc      <= 5'h0;
      epc            <= 32'h0;
      badvaddr       <= 32'h0;
      count          <= 32'h0;
      compare        <= 32'h0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      // Free-running timer; an mtc0 to COUNT overrides the increment.
      count <= wr_count ? cp0_wdata : count + 32'd1;

      // Writing COMPARE acknowledges the timer and beats a same-cycle match.
      if (wr_compare) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if (timer_hit) begin
        cause_ti <= 1'b1;
      end

      // Hardware pending bits track the lines every cycle; the timer shares
      // line 5.
      cause_ip[7:2] <= {int_in[5] | cause_ti, int_in[4:0]};

      if (wr_cause) cause_ip[1:0] <= cp0_wdata[9:8];

      if (wr_status) begin
        status_ie  <= cp0_wdata[0];
        status_exl <= cp0_wdata[1];
        status_im  <= cp0_wdata[15:8];
      end

      if (wr_epc) epc <= cp0_wdata;

      unique case (state)
        S_IDLE: begin
          if (take_exc || take_int) begin
            // With EXL already set we are inside a handler: keep the original
            // return point rather than overwrite it.
            if (!status_exl) begin
              epc      <= mem_in_ds ? mem_pc - 32'd4 : mem_pc;
              cause_bd <= mem_in_ds;
            end
            cause_exc <= take_exc ? exc_code : 5'd0;
            if (take_exc && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
              badvaddr <= exc_badaddr;
            status_exl     <= 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= EXC_VEC;
            state          <= S_WAIT_ACK;
          end else if (take_eret) begin
            status_exl     <= 1'b0;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= epc;
            state          <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          // Request held stable until fetch takes it.
          if (redirect_ack) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//
// Directed testbench for cp0_exc_ctrl. Inputs are driven 2 ns after the rising
// edge and outputs are sampled in the same window, well away from the edge.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badaddr;
  logic        eret;
  logic [5:0]  int_in;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        exl_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] v;

  always #10 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_valid       (pc_valid),
    .mem_pc         (mem_pc),
    .mem_in_ds      (mem_in_ds),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_badaddr    (exc_badaddr),
    .eret           (eret),
    .int_in         (int_in),
    .cp0_we         (cp0_we),
    .cp0_addr       (cp0_addr),
    .cp0_sel        (cp0_sel),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack),
    .exl_out        (exl_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    cp0_sel  = 3'd0;
    #1;
    d = cp0_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_addr  = a;
    cp0_sel   = 3'd0;
    cp0_wdata = d;
    tick();
    cp0_we    = 1'b0;
  endtask

  task automatic ack();
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_valid = 1'b0; mem_pc = '0; mem_in_ds = 1'b0;
    exc_valid = 1'b0; exc_code = '0; exc_badaddr = '0; eret = 1'b0;
    int_in = '0; cp0_we = 1'b0; cp0_addr = '0; cp0_sel = '0;
    cp0_wdata = '0; redirect_ack = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_rv",    redirect_valid, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_rpc",   redirect_pc, 32'h0);
    check("rst_exl",   exl_out, 1'b0);
    rd(5'd12, v); check("rst_status", v, 32'h1);
    rd(5'd13, v); check("rst_cause",  v, 32'h0);
    rd(5'd14, v); check("rst_epc",    v, 32'h0);
    rd(5'd9,  v); check("rst_count",  v, 32'h0);
    rst_n = 1'b1;

    // ---------------- syscall ----------------
    pc_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd8; mem_pc = 32'h104; mem_in_ds = 1'b0;
    tick();
    exc_valid = 1'b0; pc_valid = 1'b0;
    check("sys_rv",    redirect_valid, 1'b1);
    check("sys_flush", flush, 1'b1);
    check("sys_rpc",   redirect_pc, 32'h3000);
    check("sys_exl",   exl_out, 1'b1);
    rd(5'd14, v); check("sys_epc", v, 32'h104);
    rd(5'd13, v); check("sys_code", v[6:2], 5'd8); check("sys_bd", v[31], 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        // both must be ignored while waiting for the ack
        exc_valid = 1'b1; exc_code = 5'd10;
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD;
      end
      tick();
      exc_valid = 1'b0; cp0_we = 1'b0;
      check("sys_hold_rv",    redirect_valid, 1'b1);
      check("sys_hold_flush", flush, 1'b1);
      check("sys_hold_rpc",   redirect_pc, 32'h3000);
    end
    rd(5'd14, v); check("sys_wait_epc", v, 32'h104);
    rd(5'd13, v); check("sys_wait_code", v[6:2], 5'd8);
    ack();
    check("sys_ack_rv",    redirect_valid, 1'b0);
    check("sys_ack_flush", flush, 1'b0);
    check("sys_ack_rpc",   redirect_pc, 32'h0);
    wr(5'd12, 32'h1);
    check("idle_mtc0_exl", exl_out, 1'b0);

    // ---------------- delay slot AdEL ----------------
    pc_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd4; mem_pc = 32'h200;
    mem_in_ds = 1'b1; exc_badaddr = 32'h1003;
    tick();
    exc_valid = 1'b0; mem_in_ds = 1'b0; pc_valid = 1'b0;
    check("adel_rv",  redirect_valid, 1'b1);
    check("adel_rpc", redirect_pc, 32'h3000);
    rd(5'd14, v); check("adel_epc", v, 32'h1FC);
    rd(5'd13, v); check("adel_bd", v[31], 1'b1); check("adel_code", v[6:2], 5'd4);
    rd(5'd8,  v); check("adel_badv", v, 32'h1003);
    ack();
    check("adel_pulse_rv", redirect_valid, 1'b0);

    // ---------------- nested Ov with EXL=1 ----------------
    pc_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd12; mem_pc = 32'h300;
    exc_badaddr = 32'h5555;
    tick();
    exc_valid = 1'b0; pc_valid = 1'b0;
    check("ov_rv",  redirect_valid, 1'b1);
    check("ov_rpc", redirect_pc, 32'h3000);
    check("ov_exl", exl_out, 1'b1);
    rd(5'd14, v); check("ov_epc", v, 32'h1FC);
    rd(5'd13, v); check("ov_bd", v[31], 1'b1); check("ov_code", v[6:2], 5'd12);
    rd(5'd8,  v); check("ov_badv", v, 32'h1003);
    ack();

    // ---------------- eret ----------------
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_sel = 3'd0; cp0_wdata = 32'h400;
    #1;
    check("mfc0_old_value", cp0_rdata, 32'h1FC);
    tick();
    cp0_we = 1'b0;
    check("pre_eret_exl", exl_out, 1'b1);
    eret = 1'b1; pc_valid = 1'b1; mem_pc = 32'h480;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h999;
    tick();
    eret = 1'b0; pc_valid = 1'b0; cp0_we = 1'b0;
    check("eret_rv",  redirect_valid, 1'b1);
    check("eret_rpc", redirect_pc, 32'h400);
    check("eret_exl", exl_out, 1'b0);
    rd(5'd14, v); check("eret_epc_kept", v, 32'h400);
    ack();
    check("eret_ack_rv", redirect_valid, 1'b0);

    // ---------------- timer interrupt ----------------
    wr(5'd11, 32'd200);
    rd(5'd13, v); check("cmp_clears_ti", v[30], 1'b0);
    wr(5'd9, 32'd195);
    wr(5'd12, 32'h8001);
    rd(5'd9,  v); check("tmr_count0", v, 32'd196);
    rd(5'd13, v); check("tmr_ip15_0", v[15], 1'b0);
    repeat (4) tick();
    rd(5'd9,  v); check("tmr_count_eq", v, 32'd200);
    rd(5'd13, v); check("tmr_ti_early", v[30], 1'b0);
    tick();
    rd(5'd13, v); check("tmr_ti_set", v[30], 1'b1); check("tmr_ip15_lag", v[15], 1'b0);
    tick();
    rd(5'd13, v); check("tmr_ip15_set", v[15], 1'b1);
    pc_valid = 1'b1; mem_pc = 32'h500;
    tick();
    pc_valid = 1'b0;
    check("tint_rv",  redirect_valid, 1'b1);
    check("tint_rpc", redirect_pc, 32'h3000);
    check("tint_exl", exl_out, 1'b1);
    rd(5'd14, v); check("tint_epc", v, 32'h500);
    rd(5'd13, v); check("tint_code", v[6:2], 5'd0);
    ack();
    wr(5'd11, 32'd0);
    rd(5'd13, v); check("tmr_ti_clr", v[30], 1'b0);

    // ---------------- priority ----------------
    int_in = 6'b000001;
    wr(5'd12, 32'h0000_0401);
    check("prio_exl0", exl_out, 1'b0);
    exc_valid = 1'b1; exc_code = 5'd9; eret = 1'b1; pc_valid = 1'b1; mem_pc = 32'h600;
    tick();
    exc_valid = 1'b0; eret = 1'b0; pc_valid = 1'b0;
    check("prio_rv",  redirect_valid, 1'b1);
    check("prio_rpc", redirect_pc, 32'h3000);
    check("prio_exl", exl_out, 1'b1);
    rd(5'd13, v); check("prio_code", v[6:2], 5'd9);
    rd(5'd14, v); check("prio_epc", v, 32'h600);
    ack();
    pc_valid = 1'b1; mem_pc = 32'h680;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("prio_int_held", redirect_valid, 1'b0);
    end
    eret = 1'b1; mem_pc = 32'h700;
    tick();
    eret = 1'b0; pc_valid = 1'b0;
    check("prio_eret_rv",  redirect_valid, 1'b1);
    check("prio_eret_rpc", redirect_pc, 32'h600);
    check("prio_eret_exl", exl_out, 1'b0);
    ack();
    pc_valid = 1'b1; mem_pc = 32'h604;
    tick();
    pc_valid = 1'b0;
    check("prio_int_rv",  redirect_valid, 1'b1);
    check("prio_int_rpc", redirect_pc, 32'h3000);
    rd(5'd14, v); check("prio_int_epc", v, 32'h604);
    rd(5'd13, v); check("prio_int_code", v[6:2], 5'd0);

    // ---------------- reset while in WAIT_ACK ----------------
    rst_n = 1'b0;
    tick();
    check("wrst_rv",    redirect_valid, 1'b0);
    check("wrst_flush", flush, 1'b0);
    check("wrst_exl",   exl_out, 1'b0);
    rd(5'd12, v); check("wrst_status", v, 32'h1);
    rd(5'd9,  v); check("wrst_count", v, 32'h0);
    rst_n = 1'b1; int_in = 6'b0;
    tick();
    rd(5'd9, v); check("wrst_count_inc", v, 32'h1);

    // ---------------- register map corners ----------------
    cp0_addr = 5'd12; cp0_sel = 3'd1;
    #1;
    check("sel1_reads0", cp0_rdata, 32'h0);
    cp0_sel = 3'd0;
    rd(5'd5, v); check("unimpl_reads0", v, 32'h0);
    wr(5'd8, 32'hFFFF);
    rd(5'd8, v); check("badv_ro", v, 32'h0);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); check("cause_sw_only", v[9:2], 8'hC0); check("cause_bd_ro", v[31], 1'b0);
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_sel = 3'd1; cp0_wdata = 32'h1234;
    tick();
    cp0_we = 1'b0; cp0_sel = 3'd0;
    rd(5'd14, v); check("sel1_wr_ignored", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
